async_ram256x8: RTL and testbench

- 256-word x 8-bit RAM with one bidirectional data bus `d`, an address bus `a`, write enable `we` and output enable `oe`.
- Reads are asynchronous (combinational from `a`/`oe`). Writes and reset are synchronous to `clk`.
- Used as a general-purpose scratch memory on a shared tri-state data bus.
- The external bus master drives `d` only while asserting `we`.

---
 rtl/async_ram256x8.sv | 40 ++++
 tb/tb_async_ram256x8.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_ram256x8.sv
// async_ram256x8: 2**AW x DW scratch RAM on a shared tri-state data bus.
// Reads are combinational from the address and enables. Writes and the
// whole-array clear are taken on the rising clock edge.
module async_ram256x8 #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] a,
  inout  wire  [DW-1:0] d,
  input  logic          we,
  input  logic          oe
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic          w_drive;
  logic [DW-1:0] w_rdata;

  // Clear every word in one edge on reset; otherwise capture the bus
  // into the addressed word. Reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[a] <= d;
    end
  end

  // The bus is driven only for a read. A write (we=1) always releases it,
  // so this block never fights the external writer, whatever oe says.
  assign w_drive = oe & ~we;
  assign w_rdata = r_mem[a];
  assign d       = w_drive ? w_rdata : {DW{1'bz}};

endmodule

// File: tb/tb_async_ram256x8.sv
// Directed testbench for async_ram256x8. Inputs change on the falling
// edge; the bus is sampled a few ns later, well away from the rising edge.
module tb_async_ram256x8;

  logic       clk;
  logic       reset;
  logic [7:0] a;
  logic       we;
  logic       oe;
  logic [7:0] tb_d;
  logic       tb_drv;
  wire  [7:0] d;

  int n_vec;
  int n_err;

  assign d = tb_drv ? tb_d : 8'hzz;

  async_ram256x8 #(.AW(8), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .d     (d),
    .we    (we),
    .oe    (oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One write cycle: present address and data, take one rising edge.
  task automatic write_word(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    a      = addr;
    tb_d   = data;
    tb_drv = 1'b1;
    we     = 1'b1;
    oe     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    we     = 1'b0;
    tb_drv = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    we = 1'b0;
    oe = 1'b0;
    tb_drv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    oe = 1'b1;
    for (int i = 8'h00; i <= 8'h2F; i++) begin
      @(negedge clk);
      a = 8'(i);
      #2;
      n_vec++;
      if (d !== 8'h00) begin
        n_err++;
        $display("FAIL reset_clear a=%02h got=%02h exp=00", a, d);
      end
    end
  endtask

  task automatic test_write_readback;
    logic [7:0] exp;
    for (int i = 8'h10; i <= 8'h1F; i++) begin
      write_word(8'(i), 8'(i * 2));
    end
    @(negedge clk);
    we = 1'b0;
    oe = 1'b1;
    for (int i = 8'h00; i <= 8'h2F; i++) begin
      @(negedge clk);
      a = 8'(i);
      exp = (i >= 8'h10 && i <= 8'h1F) ? 8'(i * 2) : 8'h00;
      #2;
      n_vec++;
      if (d !== exp) begin
        n_err++;
        $display("FAIL write_readback a=%02h got=%02h exp=%02h", a, d, exp);
      end
    end
  endtask

  task automatic test_bus_release;
    // we=0, oe=0: the RAM must not drive, so the bench value is seen intact.
    // mem[0x10] holds 0x20, which would disturb 0x5A if the RAM drove.
    @(negedge clk);
    a = 8'h10;
    we = 1'b0;
    oe = 1'b0;
    tb_d = 8'h5A;
    tb_drv = 1'b1;
    #2;
    n_vec++;
    if (d !== 8'h5A) begin
      n_err++;
      $display("FAIL release_oe0 got=%02h exp=5a", d);
    end
    // Read enabled again, bench released: RAM drives mem[0x10].
    tb_drv = 1'b0;
    oe = 1'b1;
    #1;
    n_vec++;
    if (d !== 8'h20) begin
      n_err++;
      $display("FAIL release_reread got=%02h exp=20", d);
    end
    // we=1 with oe=1: the writer's value must appear without contention.
    @(negedge clk);
    a = 8'h40;
    we = 1'b1;
    oe = 1'b1;
    tb_d = 8'hA5;
    tb_drv = 1'b1;
    #2;
    n_vec++;
    if (d !== 8'hA5) begin
      n_err++;
      $display("FAIL release_we1oe1 got=%02h exp=a5", d);
    end
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    tb_drv = 1'b0;
    #2;
    n_vec++;
    if (d !== 8'hA5) begin
      n_err++;
      $display("FAIL release_written got=%02h exp=a5", d);
    end
  endtask

  task automatic test_boundary;
    logic [7:0] addrs [4];
    logic [7:0] exps  [4];
    addrs = '{8'hFF, 8'h00, 8'hFE, 8'h01};
    exps  = '{8'h5A, 8'hC3, 8'h00, 8'h00};
    write_word(8'hFF, 8'h5A);
    write_word(8'h00, 8'hC3);
    oe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = addrs[i];
      #2;
      n_vec++;
      if (d !== exps[i]) begin
        n_err++;
        $display("FAIL boundary a=%02h got=%02h exp=%02h", a, d, exps[i]);
      end
    end
  endtask

  task automatic test_reset_priority;
    logic [7:0] addrs [5];
    addrs = '{8'h00, 8'h15, 8'h1F, 8'h40, 8'hFF};
    // Reset asserted but before its edge: old contents still visible.
    @(negedge clk);
    reset = 1'b1;
    we = 1'b0;
    oe = 1'b1;
    a = 8'h15;
    #2;
    n_vec++;
    if (d !== 8'h2A) begin
      n_err++;
      $display("FAIL reset_preedge got=%02h exp=2a", d);
    end
    // Coincident write must be discarded.
    a = 8'h10;
    tb_d = 8'h77;
    tb_drv = 1'b1;
    we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    we = 1'b0;
    tb_drv = 1'b0;
    oe = 1'b1;
    #2;
    n_vec++;
    if (d !== 8'h00) begin
      n_err++;
      $display("FAIL reset_priority a=10 got=%02h exp=00", d);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = addrs[i];
      #2;
      n_vec++;
      if (d !== 8'h00) begin
        n_err++;
        $display("FAIL reset_midseq a=%02h got=%02h exp=00", a, d);
      end
    end
  endtask

  task automatic test_async_read;
    write_word(8'h80, 8'h11);
    write_word(8'h81, 8'h22);
    oe = 1'b1;
    @(negedge clk);
    a = 8'h80;
    #1;
    n_vec++;
    if (d !== 8'h11) begin
      n_err++;
      $display("FAIL async_a80 got=%02h exp=11", d);
    end
    // Address changes with no clock edge in between.
    a = 8'h81;
    #1;
    n_vec++;
    if (d !== 8'h22) begin
      n_err++;
      $display("FAIL async_a81 got=%02h exp=22", d);
    end
    a = 8'h80;
    #1;
    n_vec++;
    if (d !== 8'h11) begin
      n_err++;
      $display("FAIL async_back got=%02h exp=11", d);
    end
    // Write-then-read: new data visible right after the write edge.
    @(negedge clk);
    a = 8'h82;
    tb_d = 8'h33;
    tb_drv = 1'b1;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    tb_drv = 1'b0;
    oe = 1'b1;
    #1;
    n_vec++;
    if (d !== 8'h33) begin
      n_err++;
      $display("FAIL write_then_read got=%02h exp=33", d);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    reset  = 1'b0;
    a      = 8'h00;
    we     = 1'b0;
    oe     = 1'b0;
    tb_d   = 8'h00;
    tb_drv = 1'b0;
    repeat (2) @(posedge clk);
    test_reset;
    test_write_readback;
    test_bus_release;
    test_boundary;
    test_reset_priority;
    test_async_read;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
